// File: rtl/vv_loader_if.sv
// Bundle of element-load, memory-write, result-read and result-output signals
// between vv_loader (slave side) and its environment (master side).
interface vv_loader_if #(
    parameter int DW = 8,
    parameter int AW = 5,
    parameter int RW = 18
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic [AW-1:0] vec_a_wr_addr;
    logic [AW-1:0] vec_b_wr_addr;
    logic [DW-1:0] vec_a_wr_data;
    logic [DW-1:0] vec_b_wr_data;
    logic          vec_a_we;
    logic          vec_b_we;
    logic          vv_start;
    logic [AW-1:0] ram_rd_addr;
    logic [RW-1:0] ram_rd_data;
    logic          res_valid;
    logic          res_ready;
    logic [RW-1:0] res_data;
    logic          busy;

    modport master (
        output in_valid, in_a, in_b, ram_rd_data, res_ready,
        input  in_ready, vec_a_wr_addr, vec_b_wr_addr, vec_a_wr_data, vec_b_wr_data,
               vec_a_we, vec_b_we, vv_start, ram_rd_addr, res_valid, res_data, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, ram_rd_data, res_ready,
        output in_ready, vec_a_wr_addr, vec_b_wr_addr, vec_a_wr_data, vec_b_wr_data,
               vec_a_we, vec_b_we, vv_start, ram_rd_addr, res_valid, res_data, busy
    );
endinterface

// File: rtl/vv_loader.sv
// Loads N element pairs into the two vector memories, kicks the dot-product
// stage, waits a fixed latency, then reads and presents the result.
module vv_loader #(
    parameter int N           = 4,
    parameter int DW          = 8,
    parameter int BRAM_DEPTH  = 32,
    parameter int WAIT_CYCLES = 12
) (
    input logic       clk,
    input logic       rst,
    vv_loader_if.slave bus
);
    localparam int AW = $clog2(BRAM_DEPTH);
    localparam int RW = 2 * DW + $clog2(N);
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(WAIT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_LOAD,
        S_START,
        S_WAIT,
        S_READ,
        S_CAP,
        S_OUT
    } state_t;

    state_t        state_reg, state_next;
    logic [KW-1:0] k_reg, k_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [DW-1:0] a_reg, b_reg;
    logic [AW-1:0] wr_addr_reg;
    logic          we_reg;
    logic          vv_start_reg;
    logic [RW-1:0] res_data_reg;
    logic          in_ready;
    logic          hs;

    // Gated by rst so the producer never sees ready while reset is held.
    assign in_ready = rst && (state_reg == S_LOAD);
    assign hs       = in_ready && bus.in_valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= S_LOAD;
            k_reg     <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_LOAD: begin
                if (hs) begin
                    if (k_reg == KW'(N - 1)) begin
                        k_next     = '0;
                        state_next = S_START;
                    end else begin
                        k_next = k_reg + KW'(1);
                    end
                end
            end
            S_START: begin
                cnt_next   = CW'(WAIT_CYCLES - 1);
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_reg == '0) begin
                    state_next = S_READ;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            S_READ:  state_next = S_CAP;
            S_CAP:   state_next = S_OUT;
            S_OUT: begin
                if (bus.res_ready) begin
                    state_next = S_LOAD;
                end
            end
            default: state_next = S_LOAD;
        endcase
    end

    // Write port lags the handshake by one cycle; vv_start lands one cycle
    // after the START state so it follows the final write pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_reg        <= '0;
            b_reg        <= '0;
            wr_addr_reg  <= '0;
            we_reg       <= 1'b0;
            vv_start_reg <= 1'b0;
            res_data_reg <= '0;
        end else begin
            we_reg       <= hs;
            vv_start_reg <= (state_reg == S_START);
            if (hs) begin
                a_reg       <= bus.in_a;
                b_reg       <= bus.in_b;
                wr_addr_reg <= AW'(k_reg);
            end
            if (state_reg == S_CAP) begin
                res_data_reg <= bus.ram_rd_data;
            end
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.vec_a_wr_addr = wr_addr_reg;
    assign bus.vec_b_wr_addr = wr_addr_reg;
    assign bus.vec_a_wr_data = a_reg;
    assign bus.vec_b_wr_data = b_reg;
    assign bus.vec_a_we      = we_reg;
    assign bus.vec_b_we      = we_reg;
    assign bus.vv_start      = vv_start_reg;
    // The result lives at word 0, so the read address is 0 in READ and elsewhere.
    assign bus.ram_rd_addr   = '0;
    assign bus.res_valid     = (state_reg == S_OUT);
    assign bus.res_data      = res_data_reg;
    assign bus.busy          = (state_reg != S_LOAD);
endmodule

// File: tb/tb_vv_loader.sv
// Randomized bench for vv_loader: a behavioural memory/dot-product stage plus
// a queue-based reference for writes, start timing and the expected result.
module tb_vv_loader;
    localparam int DW = 8;
    localparam int AW = 5;
    localparam int RW = 18;
    localparam int WAIT_CYCLES = 12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vv_loader_if #(.DW(DW), .AW(AW), .RW(RW)) bus ();

    vv_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        int t;
        int a_we;
        int b_we;
        int a_addr;
        int b_addr;
        int a_data;
        int b_data;
    } wr_t;

    wr_t wr_q[$];
    int  st_q[$];
    int  rv_q[$];
    int  cyc = 0;
    bit  rv_prev = 1'b0;

    logic [DW-1:0] mem_a [32];
    logic [DW-1:0] mem_b [32];
    logic [RW-1:0] res_mem [32];

    int n_cmp = 0;
    int n_err = 0;

    bit [7:0] va [4];
    bit [7:0] vb [4];

    // Environment: vector memories, dot-product stage and result memory.
    always @(posedge clk) begin
        wr_t e;
        int  s;
        if (bus.vec_a_we || bus.vec_b_we) begin
            e.t = cyc;
            e.a_we = int'(bus.vec_a_we);
            e.b_we = int'(bus.vec_b_we);
            e.a_addr = int'(bus.vec_a_wr_addr);
            e.b_addr = int'(bus.vec_b_wr_addr);
            e.a_data = int'(bus.vec_a_wr_data);
            e.b_data = int'(bus.vec_b_wr_data);
            wr_q.push_back(e);
        end
        if (bus.vec_a_we) mem_a[bus.vec_a_wr_addr] <= bus.vec_a_wr_data;
        if (bus.vec_b_we) mem_b[bus.vec_b_wr_addr] <= bus.vec_b_wr_data;
        if (bus.vv_start) begin
            st_q.push_back(cyc);
            s = 0;
            for (int i = 0; i < 4; i++) s = s + mem_a[i] * mem_b[i];
            res_mem[0] <= RW'(s);
        end
        if (bus.res_valid && !rv_prev) rv_q.push_back(cyc);
        rv_prev = bus.res_valid;
        bus.ram_rd_data <= res_mem[bus.ram_rd_addr];
        cyc = cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: in_valid held high, 1: pattern 1,0,0,1,1,0,1, 2: random gaps
    task automatic do_op(input int mode, input int hold, input bit keep_valid, input bit abort);
        int wb, sb, rb, k, c, hs_t, expv;
        bit v;
        logic [6:0] pat;
        wr_t e;
        pat = 7'b1011001;
        wb = wr_q.size();
        sb = st_q.size();
        rb = rv_q.size();
        expv = 0;
        k = 0;
        c = 0;
        hs_t = 0;
        while (k < 4 && c < 200) begin
            case (mode)
                0: v = 1'b1;
                1: v = pat[c % 7];
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            bus.in_valid  = v;
            bus.in_a      = v ? va[k] : DW'($urandom);
            bus.in_b      = v ? vb[k] : DW'($urandom);
            bus.res_ready = keep_valid ? 1'b1 : 1'(($urandom));
            if (v && bus.in_ready) begin
                expv = expv + va[k] * vb[k];
                k++;
                hs_t = cyc;
            end
            tick();
            c++;
        end
        chk("load_handshakes", k, 4);
        bus.in_valid  = keep_valid;
        bus.in_a      = DW'($urandom);
        bus.in_b      = DW'($urandom);
        bus.res_ready = keep_valid;

        if (abort) begin
            c = 0;
            while (st_q.size() == sb && c < 50) begin
                tick();
                c++;
            end
            repeat (3) tick();
            chk("abort_in_wait_busy", bus.busy, 1);
            rst = 1'b0;
            #1;
            chk("abort_in_ready_low", bus.in_ready, 0);
            tick();
            chk("abort_res_valid", bus.res_valid, 0);
            chk("abort_vv_start", bus.vv_start, 0);
            chk("abort_we", {bus.vec_a_we, bus.vec_b_we}, 0);
            chk("abort_busy", bus.busy, 0);
            chk("abort_res_data", bus.res_data, 0);
            chk("abort_addr", {bus.vec_a_wr_addr, bus.vec_b_wr_addr}, 0);
            chk("abort_wdata", {bus.vec_a_wr_data, bus.vec_b_wr_data}, 0);
            rst = 1'b1;
            #1;
            chk("abort_in_ready_release", bus.in_ready, 1);
            repeat (25) begin
                tick();
                chk("abort_no_res_valid", bus.res_valid, 0);
            end
            chk("abort_start_count", st_q.size() - sb, 1);
            chk("abort_rv_count", rv_q.size() - rb, 0);
            return;
        end

        c = 0;
        while (!bus.res_valid && c < 100) begin
            tick();
            c++;
        end
        chk("res_valid_seen", bus.res_valid, 1);
        chk("write_count", wr_q.size() - wb, 4);
        for (int i = 0; i < 4 && wb + i < wr_q.size(); i++) begin
            e = wr_q[wb + i];
            chk("wr_we_pair", {e.a_we[0], e.b_we[0]}, 2'b11);
            chk("wr_addr_a", e.a_addr, i);
            chk("wr_addr_b", e.b_addr, i);
            chk("wr_data_a", e.a_data, va[i]);
            chk("wr_data_b", e.b_data, vb[i]);
        end
        chk("last_write_time", wr_q[wr_q.size() - 1].t, hs_t + 1);
        chk("start_count", st_q.size() - sb, 1);
        if (st_q.size() > sb) chk("start_time", st_q[sb], hs_t + 2);
        chk("res_data", bus.res_data, expv);
        for (int h = 0; h < hold; h++) begin
            bus.res_ready = 1'b0;
            tick();
            chk("hold_res_valid", bus.res_valid, 1);
            chk("hold_res_data", bus.res_data, expv);
            chk("hold_in_ready", bus.in_ready, 0);
            chk("hold_busy", bus.busy, 1);
        end
        bus.res_ready = 1'b1;
        tick();
        chk("rv_count", rv_q.size() - rb, 1);
        if (rv_q.size() > rb) chk("res_valid_time", rv_q[rb], hs_t + 4 + WAIT_CYCLES);
        chk("after_res_valid", bus.res_valid, 0);
        chk("after_in_ready", bus.in_ready, 1);
        chk("after_busy", bus.busy, 0);
        chk("no_extra_writes", wr_q.size() - wb, 4);
        bus.res_ready = keep_valid;
    endtask

    task automatic set_random();
        for (int i = 0; i < 4; i++) begin
            va[i] = 8'($urandom_range(0, 255));
            vb[i] = 8'($urandom_range(0, 255));
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) res_mem[i] = RW'($urandom);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.res_ready = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_vv_start", bus.vv_start, 0);
        chk("rst_we", {bus.vec_a_we, bus.vec_b_we}, 0);
        chk("rst_res_data", bus.res_data, 0);
        chk("rst_addr", {bus.vec_a_wr_addr, bus.vec_b_wr_addr, bus.ram_rd_addr}, 0);
        rst = 1'b1;
        #1;
        chk("release_in_ready", bus.in_ready, 1);

        va = '{8'd1, 8'd2, 8'd3, 8'd4};
        vb = '{8'd5, 8'd6, 8'd7, 8'd8};
        do_op(0, 0, 1'b0, 1'b0);

        va = '{8'd255, 8'd255, 8'd255, 8'd255};
        vb = '{8'd255, 8'd255, 8'd255, 8'd255};
        do_op(0, 1, 1'b0, 1'b0);

        set_random();
        do_op(1, 0, 1'b0, 1'b0);

        set_random();
        do_op(2, 5, 1'b0, 1'b0);

        set_random();
        do_op(2, 0, 1'b0, 1'b1);
        set_random();
        do_op(0, 2, 1'b0, 1'b0);

        set_random();
        do_op(0, 0, 1'b1, 1'b0);
        set_random();
        do_op(0, 0, 1'b1, 1'b0);
        bus.in_valid = 1'b0;
        bus.res_ready = 1'b0;

        for (int r = 0; r < 6; r++) begin
            set_random();
            do_op(2, $urandom_range(0, 3), 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
